hamming_stream_encoder: RTL and testbench
=========================================

# hamming_stream_encoder

Parametrised, pipelined Hamming encoder: the streaming successor to the 128-bit combinational Hamming(7,4) encoder. It splits each input word into NIB 4-bit groups and encodes every group as Hamming(7,4), or as extended Hamming(8,4) SEC-DED when EXT=1. Input and output use a valid/ready handshake with a 2-entry output buffer, so it runs at full throughput under backpressure. It sits between the data source and the channel/storage path and feeds the matching decoder.

## Interface
- NIB, 32, number of 4-bit data groups per word (≥1)
- EXT, 0, 0 = Hamming(7,4), group width G=7; 1 = SEC-DED (8,4), G=8
- CNTW, 16, width of word_count
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  accept gate; 0 blocks new input while the output side keeps draining
- in_valid  input  1  data_in is valid
- in_ready  output  1  block can accept this cycle
- data_in  input  4*NIB  group i = data_in[4i+3:4i]
- out_valid  output  1  encoded_data is valid
- out_ready  input  1  downstream accepts
- encoded_data  output  G*NIB  encoded word
- word_count  output  CNTW  number of completed output handshakes, modulo 2^CNTW

## Operation
- Group i encoding, with d = data_in[4i+3:4i]:
  - p0 = d0^d1^d3; p1 = d0^d2^d3; p2 = d1^d2^d3
  - encoded_data[iG+3:iG] = d
  - encoded_data[iG+6:iG+4] = {p2,p1,p0}
  - EXT=1: encoded_data[iG+7] = XOR of bits iG..iG+6, which equals d0^d1^d2 (even parity over the 8 bits)
- Encoding is combinational on data_in. The result is captured into the buffer on acceptance.
- Buffer: output register OR (drives encoded_data and out_valid) plus skid register SK (flag sk_valid).
- in_ready = enable & ~sk_valid & ~rst. It is a function of registered state only, with no combinational path from out_ready.
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- Per-edge update:
  - accept, and (OR empty or pop): OR ← new word.
  - accept, and OR full with no pop: SK ← new word, sk_valid ← 1.
  - pop with sk_valid: OR ← SK, sk_valid ← 0. If an accept happens in the same cycle, it cannot occur, because in_ready=0.
  - pop with no accept and no sk_valid: out_valid ← 0. encoded_data holds its last value.
- Ordering is strict FIFO. No word is dropped or duplicated.
- word_count increments by 1 on every pop and wraps from 2^CNTW−1 to 0.
- enable=0:
  - No accepts.
  - Pending OR/SK contents still drain normally.
  - word_count still counts pops.
- States, implied by (out_valid, sk_valid):
  - EMPTY (0,0) → ONE on accept.
  - ONE (1,0) → EMPTY on pop without accept; → FULL on accept without pop; stays ONE on pop together with accept.
  - FULL (1,1) → ONE on pop.

## Timing
- Latency: a word accepted at edge k appears with out_valid=1 immediately after edge k (1 cycle).
- Throughput: 1 word/cycle while out_ready=1.
- Under backpressure, 2 words are held, then in_ready falls the cycle after the second accept.
- in_ready returns to 1 the cycle after the pop that empties SK (given enable=1).
- Reset, asynchronous, takes effect immediately on assertion:
  - out_valid=0, sk_valid=0, in_ready=0
  - encoded_data=0, SK contents=0, word_count=0
- Reset mid-operation discards buffered words. The first accept after release is counted from word_count=0.
- in_ready may rise in the first cycle after rst deasserts (if enable=1).

## Test plan
- NIB=1, EXT=0: data_in=4'hB → encoded_data=7'h1B. 4'hF → 7'h7F. 4'h0 → 7'h00. 4'h1 → 7'h31.
- NIB=1, EXT=1: data_in=4'hB → 8'h1B. 4'hF → 8'hFF. 4'h1 → 8'hB1. Also check all 16 values against the reference equations.
- Defaults (NIB=32, EXT=0):
  - data_in = all ones → encoded_data = 224 ones.
  - data_in = 128'h1 → encoded_data = 224'h31.
  - Streaming 8 back-to-back words with out_ready=1 → out_valid continuous, 1-cycle latency, word_count=8.
- Backpressure: out_ready=0, offer words A, B, C → A and B accepted, in_ready=0, C held. Raise out_ready → output order A, B, C with no loss or gaps.
- enable dropped after A is accepted, with out_ready=1 → A is emitted, no further accepts while enable=0, and in_ready=0 throughout.
- CNTW=4: 16 pops → word_count wraps to 0. Then assert rst while the buffer is FULL → all outputs 0 immediately, and no stale word is emitted after release.

Source files
------------

// File: rtl/hamming_stream_encoder.sv
// Pipelined Hamming(7,4) / SEC-DED(8,4) stream encoder.
// Each 4-bit group of data_in is encoded on its own. The encoded word is
// handed out through a 2-entry output buffer (output register + skid
// register) with a valid/ready handshake on both sides.
module hamming_stream_encoder #(
  parameter int NIB  = 32,
  parameter int EXT  = 0,
  parameter int CNTW = 16,
  localparam int G   = (EXT != 0) ? 8 : 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*NIB-1:0]    data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [G*NIB-1:0]    encoded_data,
  output logic [CNTW-1:0]     word_count
);

  // Buffer occupancy: EMPTY (OR empty), ONE (OR full), FULL (OR and SK full)
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [G*NIB-1:0]   enc_word;
  logic [G*NIB-1:0]   out_word;
  logic [G*NIB-1:0]   skid_word;
  logic               sk_valid;
  logic               accept;
  logic               pop;
  logic               load_out_new;
  logic               load_out_skid;
  logic               load_skid;

  // Per-group encoder: data in the low nibble, parity {p2,p1,p0} above it,
  // and in SEC-DED mode an overall even-parity bit on top.
  for (genvar i = 0; i < NIB; i++) begin : g_grp
    logic [3:0] d;
    logic [2:0] p;
    assign d = data_in[4*i +: 4];
    assign p = {d[1] ^ d[2] ^ d[3],
                d[0] ^ d[2] ^ d[3],
                d[0] ^ d[1] ^ d[3]};
    assign enc_word[G*i +: 7] = {p, d};
    if (EXT != 0) begin : g_ext
      // XOR of all seven lower bits reduces to d0^d1^d2
      assign enc_word[G*i + 7] = d[0] ^ d[1] ^ d[2];
    end
  end

  // Flags are decoded from the occupancy state; in_ready depends only on
  // registered state, enable and reset, never on out_ready.
  assign out_valid    = (state != S_EMPTY);
  assign sk_valid     = (state == S_FULL);
  assign in_ready     = enable & ~sk_valid & ~rst;
  assign accept       = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign encoded_data = out_word;

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next occupancy and buffer load controls
  always_comb begin
    state_nxt     = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          state_nxt    = S_ONE;
          load_out_new = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          load_out_new = 1'b1;
        end else if (accept) begin
          state_nxt = S_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // accept cannot happen here: in_ready is low while SK is occupied
        if (pop) begin
          state_nxt     = S_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = S_EMPTY;
      end
    endcase
  end

  // Output and skid data registers; OR keeps its value when it empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_word  <= '0;
      skid_word <= '0;
    end else begin
      if (load_out_new) begin
        out_word <= enc_word;
      end else if (load_out_skid) begin
        out_word <= skid_word;
      end
      if (load_skid) begin
        skid_word <= enc_word;
      end
    end
  end

  // Count of completed output handshakes, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Self-checking bench for hamming_stream_encoder: a default-size instance
// driven against a queue-based reference model, plus two single-group
// instances (Hamming(7,4) and SEC-DED) for encoding, wrap and reset cases.
module tb_hamming_stream_encoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [223:0] encoded_data;
  logic [15:0]  word_count;

  logic         s_rst;
  logic         s_enable;
  logic         s_valid;
  logic         s_ready;
  logic [3:0]   s_data;
  logic         n_in_ready;
  logic         n_out_valid;
  logic [6:0]   n_enc;
  logic [3:0]   n_cnt;
  logic         e_in_ready;
  logic         e_out_valid;
  logic [7:0]   e_enc;
  logic [3:0]   e_cnt;

  int unsigned  checks   = 0;
  int unsigned  failures = 0;

  logic [223:0] exp_q[$];
  int unsigned  exp_cnt;

  hamming_stream_encoder u_def (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .encoded_data(encoded_data), .word_count(word_count)
  );

  hamming_stream_encoder #(.NIB(1), .EXT(0), .CNTW(4)) u_n1 (
    .clk(clk), .rst(s_rst), .enable(s_enable), .in_valid(s_valid),
    .in_ready(n_in_ready), .data_in(s_data), .out_valid(n_out_valid),
    .out_ready(s_ready), .encoded_data(n_enc), .word_count(n_cnt)
  );

  hamming_stream_encoder #(.NIB(1), .EXT(1), .CNTW(4)) u_ext (
    .clk(clk), .rst(s_rst), .enable(s_enable), .in_valid(s_valid),
    .in_ready(e_in_ready), .data_in(s_data), .out_valid(e_out_valid),
    .out_ready(s_ready), .encoded_data(e_enc), .word_count(e_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference encoding built from the parity equations; the SEC-DED bit is
  // derived as even parity over the 7-bit codeword by counting ones.
  function automatic logic [255:0] ref_enc(input int nib, input bit ext, input logic [127:0] d);
    logic [255:0] r;
    logic [3:0]   v;
    logic [7:0]   cw;
    int           g;
    r = '0;
    g = ext ? 8 : 7;
    for (int i = 0; i < nib; i++) begin
      v  = 4'(d >> (4 * i));
      cw = {4'b0000, v};
      cw[4] = v[0] ^ v[1] ^ v[3];
      cw[5] = v[0] ^ v[2] ^ v[3];
      cw[6] = v[1] ^ v[2] ^ v[3];
      if (ext && ($countones(cw) % 2 == 1)) cw[7] = 1'b1;
      r = r | (256'(cw) << (g * i));
    end
    return r;
  endfunction

  // One cycle on the default instance: drive, check against the model, then
  // advance the model by what the coming edge must do.
  task automatic step(input logic iv, input logic [127:0] d, input logic orr, input logic en);
    bit acc;
    bit pp;
    in_valid  = iv;
    data_in   = d;
    out_ready = orr;
    enable    = en;
    #1;
    check_eq("out_valid", 256'(out_valid), 256'(exp_q.size() > 0));
    check_eq("in_ready", 256'(in_ready), 256'(en && exp_q.size() < 2));
    if (exp_q.size() > 0) check_eq("data", 256'(encoded_data), 256'(exp_q[0]));
    check_eq("count", 256'(word_count), 256'(exp_cnt % 65536));
    acc = iv && en && (exp_q.size() < 2);
    pp  = (exp_q.size() > 0) && orr;
    if (pp) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    if (acc) exp_q.push_back(224'(ref_enc(32, 1'b0, d)));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_ov", 256'(out_valid), 256'(0));
    check_eq("rst_ir", 256'(in_ready), 256'(0));
    check_eq("rst_data", 256'(encoded_data), 256'(0));
    check_eq("rst_cnt", 256'(word_count), 256'(0));
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] wa, wb, wc, rnd;
    logic [255:0] k;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    s_rst = 1'b1; s_enable = 1'b0; s_valid = 1'b0; s_ready = 1'b0; s_data = '0;
    exp_cnt = 0;
    #2;
    check_eq("init_ov", 256'(out_valid), 256'(0));
    check_eq("init_ir", 256'(in_ready), 256'(0));
    check_eq("init_data", 256'(encoded_data), 256'(0));
    check_eq("init_cnt", 256'(word_count), 256'(0));
    check_eq("init_e_ov", 256'(e_out_valid), 256'(0));
    check_eq("init_n_ir", 256'(n_in_ready), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_rst = 1'b0;

    // Default-size constant vectors
    step(1'b1, '1, 1'b1, 1'b1);
    k = '0;
    k[223:0] = '1;
    check_eq("ones", 256'(encoded_data), k);
    step(1'b1, 128'h1, 1'b1, 1'b1);
    check_eq("one_31", 256'(encoded_data), 256'h31);
    step(1'b0, '0, 1'b1, 1'b1);

    // 8 back-to-back words from a clean count
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, rnd, 1'b1, 1'b1);
    end
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("cnt8", 256'(word_count), 256'(8));

    // Backpressure: A and B fill the buffer, C waits
    wa = {$urandom, $urandom, $urandom, $urandom};
    wb = {$urandom, $urandom, $urandom, $urandom};
    wc = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, wa, 1'b0, 1'b1);
    step(1'b1, wb, 1'b0, 1'b1);
    step(1'b1, wc, 1'b0, 1'b1);
    check_eq("bp_full_ir", 256'(in_ready), 256'(0));
    step(1'b1, wc, 1'b0, 1'b1);
    step(1'b1, wc, 1'b1, 1'b1);
    step(1'b1, wc, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);

    // enable dropped after one accept
    step(1'b1, wa, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, wb, 1'b1, 1'b0);

    // Randomised traffic, then a reset with words in flight
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom % 4) != 0, rnd, ($urandom % 3) != 0, ($urandom % 8) != 0);
    end
    step(1'b1, wa, 1'b0, 1'b1);
    step(1'b1, wb, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom % 2) != 0, rnd, ($urandom % 2) != 0, 1'b1);
    end

    // Single-group instances: all 16 values, continuous stream
    s_enable = 1'b1;
    s_ready  = 1'b1;
    for (int v = 0; v < 16; v++) begin
      s_valid = 1'b1;
      s_data  = 4'(v);
      @(posedge clk);
      #1;
      check_eq("n1_enc", 256'(n_enc), ref_enc(1, 1'b0, 128'(v)));
      check_eq("ext_enc", 256'(e_enc), ref_enc(1, 1'b1, 128'(v)));
      check_eq("ext_ov", 256'(e_out_valid), 256'(1));
      check_eq("ext_cnt", 256'(e_cnt), 256'(v));
      case (v)
        0:  begin check_eq("n1_h0", 256'(n_enc), 256'h00); end
        1:  begin check_eq("n1_h1", 256'(n_enc), 256'h31); check_eq("ext_h1", 256'(e_enc), 256'hB1); end
        11: begin check_eq("n1_hB", 256'(n_enc), 256'h1B); check_eq("ext_hB", 256'(e_enc), 256'h1B); end
        15: begin check_eq("n1_hF", 256'(n_enc), 256'h7F); check_eq("ext_hF", 256'(e_enc), 256'hFF); end
        default: ;
      endcase
    end
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("wrap_ext", 256'(e_cnt), 256'(0));
    check_eq("wrap_n1", 256'(n_cnt), 256'(0));
    check_eq("drain_ov", 256'(e_out_valid), 256'(0));

    // Fill to FULL, then reset asynchronously
    s_valid = 1'b1; s_data = 4'h3;
    @(posedge clk); #1;
    s_data = 4'h5;
    @(posedge clk); #1;
    s_ready = 1'b0; s_data = 4'h9;
    @(posedge clk); #1;
    check_eq("full_ir", 256'(e_in_ready), 256'(0));
    check_eq("full_cnt", 256'(e_cnt), 256'(1));
    check_eq("full_enc", 256'(e_enc), ref_enc(1, 1'b1, 128'h5));
    s_valid = 1'b0;
    #2;
    s_rst = 1'b1;
    #1;
    check_eq("arst_ov", 256'(e_out_valid), 256'(0));
    check_eq("arst_ir", 256'(e_in_ready), 256'(0));
    check_eq("arst_enc", 256'(e_enc), 256'(0));
    check_eq("arst_cnt", 256'(e_cnt), 256'(0));
    @(posedge clk); #1;
    s_rst = 1'b0;
    s_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("post_ov", 256'(e_out_valid), 256'(0));
      check_eq("post_ir", 256'(e_in_ready), 256'(1));
    end
    s_valid = 1'b1; s_data = 4'h6;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check_eq("post_enc", 256'(e_enc), ref_enc(1, 1'b1, 128'h6));
    check_eq("post_ov1", 256'(e_out_valid), 256'(1));
    @(posedge clk); #1;
    check_eq("post_cnt", 256'(e_cnt), 256'(1));
    check_eq("post_ov0", 256'(e_out_valid), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
